// File: rtl/game_pkg.sv
// Shared screen codes and end-of-game sequencer state encoding.
package game_pkg;

    localparam logic [1:0] SCREEN_TITLE = 2'b00;
    localparam logic [1:0] SCREEN_PLAY  = 2'b01;
    localparam logic [1:0] SCREEN_END   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_FIRE      = 2'b10,
        ST_WAIT_EXIT = 2'b11
    } end_seq_state_t;

endpackage

// File: rtl/end_game_sequencer_blink.sv
// Free-running modulo-COUNT ticker with synchronous clear; wrap marks the last count.
module blink_ticker #(
    parameter int COUNT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic wrap
);
    localparam int W = $clog2(COUNT + 1);
    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [W-1:0] cnt_r;

    assign wrap = (cnt_r == LAST);

    // Modulo counter, held at zero while cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {W{1'b0}};
        end else if (clear || wrap) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_r + W'(1);
        end
    end

endmodule

// File: rtl/end_game_sequencer.sv
// End-screen sequencer: auto-restart timeout, button skip after hold-off,
// winner blink phase and a single reset-all pulse per end-screen visit.
module end_game_sequencer
    import game_pkg::*;
#(
    parameter int                  SCREEN_W               = 2,
    parameter logic [SCREEN_W-1:0] END_SCREEN             = SCREEN_W'(SCREEN_END),
    parameter int                  END_TIMER_CLK_COUNT    = 1,
    parameter int                  SKIP_HOLDOFF_CLK_COUNT = 0,
    parameter int                  BLINK_CLK_COUNT        = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SCREEN_W-1:0] current_screen,
    input  logic                any_button,
    output logic                trigger_reset_all,
    output logic                end_active,
    output logic                blink_on
);
    localparam int CNT_W = $clog2(END_TIMER_CLK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(END_TIMER_CLK_COUNT - 1);

    end_seq_state_t state_r;
    end_seq_state_t state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic button_q_r;
    logic on_end_s;
    logic holdoff_ok_s;
    logic timeout_s;
    logic skip_s;
    logic wrap_s;
    logic trigger_next_s;
    logic active_next_s;
    logic blink_next_s;

    blink_ticker #(
        .COUNT (BLINK_CLK_COUNT)
    ) u_blink (
        .clk   (clk),
        .reset (reset),
        .clear (state_r != ST_RUN),
        .wrap  (wrap_s)
    );

    // A zero hold-off makes every count eligible, so no comparator is built
    generate
        if (SKIP_HOLDOFF_CLK_COUNT == 0) begin : g_no_holdoff
            assign holdoff_ok_s = 1'b1;
        end else begin : g_holdoff
            localparam logic [CNT_W-1:0] CNT_SKIP = CNT_W'(SKIP_HOLDOFF_CLK_COUNT);
            assign holdoff_ok_s = (cnt_r >= CNT_SKIP);
        end
    endgenerate

    assign on_end_s  = (current_screen == END_SCREEN);
    assign timeout_s = (cnt_r == CNT_LAST);
    assign skip_s    = any_button & ~button_q_r & holdoff_ok_s;

    // Next state and next registered output values
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (on_end_s) state_next_s = ST_RUN;
                else          state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                // leaving the screen beats both timeout and skip
                if (!on_end_s)                state_next_s = ST_IDLE;
                else if (timeout_s || skip_s) state_next_s = ST_FIRE;
                else                          state_next_s = ST_RUN;
            end
            ST_FIRE: begin
                state_next_s = ST_WAIT_EXIT;
            end
            ST_WAIT_EXIT: begin
                if (!on_end_s) state_next_s = ST_IDLE;
                else           state_next_s = ST_WAIT_EXIT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        trigger_next_s = (state_next_s == ST_FIRE);
        active_next_s  = (state_next_s == ST_RUN) || (state_next_s == ST_FIRE);
        blink_next_s   = 1'b0;
        if (state_next_s == ST_RUN) begin
            if (state_r == ST_RUN) blink_next_s = blink_on ^ wrap_s;
            else                   blink_next_s = 1'b1;
        end else begin
            blink_next_s = 1'b0;
        end
    end

    // State, timeout counter, button history and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            cnt_r             <= {CNT_W{1'b0}};
            button_q_r        <= 1'b0;
            trigger_reset_all <= 1'b0;
            end_active        <= 1'b0;
            blink_on          <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            button_q_r        <= any_button;
            trigger_reset_all <= trigger_next_s;
            end_active        <= active_next_s;
            blink_on          <= blink_next_s;
            if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_end_game_sequencer.sv
// Bench for end_game_sequencer: two parameter sets share stimulus; a visit-level
// model checks every cycle, plus directed scenarios with literal expectations.
module tb_end_game_sequencer;

    localparam logic [1:0] END_S = 2'b10;
    localparam int T0 = 10, S0 = 4, B0 = 3;
    localparam int T1 = 1,  S1 = 0, B1 = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] screen = 2'b00;
    logic       button = 1'b0;
    logic [1:0] trig;
    logic [1:0] active;
    logic [1:0] blink;

    int n_cmp = 0;
    int n_bad = 0;
    int e = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    end_game_sequencer #(
        .SCREEN_W(2), .END_SCREEN(END_S), .END_TIMER_CLK_COUNT(T0),
        .SKIP_HOLDOFF_CLK_COUNT(S0), .BLINK_CLK_COUNT(B0)
    ) dut_main (
        .clk(clk), .reset(reset), .current_screen(screen), .any_button(button),
        .trigger_reset_all(trig[0]), .end_active(active[0]), .blink_on(blink[0])
    );

    end_game_sequencer #(
        .SCREEN_W(2), .END_SCREEN(END_S), .END_TIMER_CLK_COUNT(T1),
        .SKIP_HOLDOFF_CLK_COUNT(S1), .BLINK_CLK_COUNT(B1)
    ) dut_min (
        .clk(clk), .reset(reset), .current_screen(screen), .any_button(button),
        .trigger_reset_all(trig[1]), .end_active(active[1]), .blink_on(blink[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Visit-level model: elapsed edges since arming, fired flag, waiting-for-exit flag
    bit running[2];
    bit fire[2];
    bit waiting[2];
    int k_run[2];
    bit btn_q;
    bit valid = 1'b0;

    always @(posedge clk) begin
        bit rise;
        int t, s;
        rise = button && !btn_q;
        for (int i = 0; i < 2; i++) begin
            t = (i == 0) ? T0 : T1;
            s = (i == 0) ? S0 : S1;
            if (reset) begin
                running[i] = 1'b0; fire[i] = 1'b0; waiting[i] = 1'b0; k_run[i] = 0;
            end else if (fire[i]) begin
                fire[i] = 1'b0; waiting[i] = 1'b1;
            end else if (running[i]) begin
                if (screen != END_S) begin
                    running[i] = 1'b0;
                end else if ((k_run[i] + 1 == t) || (rise && k_run[i] >= s)) begin
                    running[i] = 1'b0; fire[i] = 1'b1;
                end else begin
                    k_run[i] = k_run[i] + 1;
                end
            end else if (waiting[i]) begin
                if (screen != END_S) waiting[i] = 1'b0;
            end else if (screen == END_S) begin
                running[i] = 1'b1; k_run[i] = 0;
            end
        end
        btn_q = reset ? 1'b0 : button;
        if (reset) valid = 1'b1;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (valid) begin
            for (int i = 0; i < 2; i++) begin
                int b;
                b = (i == 0) ? B0 : B1;
                chk($sformatf("model_trig%0d", i), trig[i], fire[i]);
                chk($sformatf("model_active%0d", i), active[i], running[i] || fire[i]);
                chk($sformatf("model_blink%0d", i), blink[i],
                    running[i] && (((k_run[i] / b) % 2) == 0));
            end
        end
    end

    task automatic until_e(input int k);
        while (e < k) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; screen = 2'b00; button = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Hold end screen
        @(negedge clk);
        do_reset();
        chk("rst_trig", trig, 2'b00);
        chk("rst_active", active, 2'b00);
        chk("rst_blink", blink, 2'b00);
        screen = END_S; e = -1;
        until_e(0);
        chk("A_e0_active", active, 2'b11);
        chk("A_e0_blink", blink, 2'b11);
        chk("A_e0_trig", trig[0], 1'b0);
        until_e(1);
        chk("A_min_e1_trig", trig[1], 1'b1);
        chk("A_min_e1_blink", blink[1], 1'b0);
        until_e(3);  chk("A_e3_blink", blink[0], 1'b0);
        until_e(6);  chk("A_e6_blink", blink[0], 1'b1);
        until_e(9);  chk("A_e9_blink", blink[0], 1'b0);
        chk("A_e9_trig", trig[0], 1'b0);
        until_e(10); chk("A_e10_trig", trig[0], 1'b1);
        until_e(11); chk("A_e11_trig", trig[0], 1'b0);
        chk("A_e11_active", active[0], 1'b0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (trig[0] === 1'b1) pulses++;
        end
        chk("A_no_repulse", pulses, 0);

        // Skip before hold-off, then valid skip
        do_reset();
        screen = END_S; e = -1;
        until_e(1); button = 1'b1;
        until_e(2); chk("B_e2_ignored", trig[0], 1'b0); button = 1'b0;
        until_e(5); chk("B_e5_trig", trig[0], 1'b0);
        button = 1'b1;
        until_e(6); chk("B_e6_skip", trig[0], 1'b1);
        button = 1'b0;
        until_e(7); chk("B_e7_trig", trig[0], 1'b0);
        chk("B_e7_active", active[0], 1'b0);

        // Held button is not a press
        do_reset();
        screen = END_S; button = 1'b1; e = -1;
        until_e(9);  chk("C_e9_trig", trig[0], 1'b0); chk("C_e9_active", active[0], 1'b1);
        until_e(10); chk("C_e10_trig", trig[0], 1'b1);
        until_e(11); chk("C_e11_trig", trig[0], 1'b0);
        button = 1'b0;

        // Leave screen before timeout, re-enter later
        do_reset();
        screen = END_S; e = -1;
        until_e(8); screen = 2'b00;
        until_e(9);
        chk("D_e9_trig", trig[0], 1'b0);
        chk("D_e9_active", active[0], 1'b0);
        chk("D_e9_blink", blink[0], 1'b0);
        until_e(19); screen = END_S;
        until_e(20); chk("D_e20_active", active[0], 1'b1);
        until_e(29); chk("D_e29_trig", trig[0], 1'b0);
        until_e(30); chk("D_e30_trig", trig[0], 1'b1);

        // Reset mid-run
        do_reset();
        screen = END_S; e = -1;
        until_e(4); reset = 1'b1;
        until_e(5);
        chk("E_e5_trig", trig, 2'b00);
        chk("E_e5_active", active, 2'b00);
        chk("E_e5_blink", blink, 2'b00);
        reset = 1'b0;
        until_e(6);  chk("E_e6_active", active[0], 1'b1); chk("E_e6_blink", blink[0], 1'b1);
        until_e(15); chk("E_e15_trig", trig[0], 1'b0);
        until_e(16); chk("E_e16_trig", trig[0], 1'b1);

        // Minimum parameters: press coincident with timeout gives one pulse
        do_reset();
        screen = END_S; e = -1;
        until_e(0); button = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            until_e(k);
            if (k == 1) chk("F_e1_trig", trig[1], 1'b1);
            if (trig[1] === 1'b1) pulses++;
        end
        chk("F_single_pulse", pulses, 1);
        button = 1'b0;

        // Randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0)
                screen = $urandom_range(0, 1) ? END_S : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) button = ~button;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
